lsu_axi_bridge: RTL and testbench
=================================

# lsu_axi_bridge

Bridges the LSU's word-aligned memory requests onto an AXI4-Lite master port. It replaces direct simulator memory calls with a real bus transaction. The block sits between the LSU (upstream; supplies word address, write data and byte mask) and the data-side interconnect/SRAM (downstream). It holds exactly one outstanding transaction, stalls the pipeline through `req_ready_o`, and returns the raw 32-bit word plus an error flag to the LSU's load-alignment logic.

## Interface
- `XLEN`, 32, data/address width
- `TIMEOUT_CYCLES`, 255, watchdog limit; used only with `LSU_BRIDGE_TIMEOUT_EN`
---
- `clk_i` in 1: clock; the only clock; all logic is on its rising edge
- `rst_ni` in 1: reset, asynchronous, active-low
- `req_valid_i` in 1: LSU request valid
- `req_ready_o` out 1: bridge can accept a request
- `req_we_i` in 1: 1 = store, 0 = load
- `req_addr_i` in XLEN: byte address; bits [1:0] are ignored
- `req_wdata_i` in XLEN: store data, already lane-aligned
- `req_wmask_i` in 4: byte strobes
- `resp_valid_o` out 1: response valid
- `resp_ready_i` in 1: LSU accepts the response
- `resp_rdata_o` out XLEN: load word; 0 for stores
- `resp_err_o` out 1: bus error (RRESP/BRESP bit 1) or timeout
- `m_araddr_o` out XLEN, `m_arvalid_o` out 1, `m_arready_i` in 1: AXI read address channel
- `m_rdata_i` in XLEN, `m_rresp_i` in 2, `m_rvalid_i` in 1, `m_rready_o` out 1: AXI read data channel
- `m_awaddr_o` out XLEN, `m_awvalid_o` out 1, `m_awready_i` in 1: AXI write address channel
- `m_wdata_o` out XLEN, `m_wstrb_o` out 4, `m_wvalid_o` out 1, `m_wready_i` in 1: AXI write data channel
- `m_bresp_i` in 2, `m_bvalid_i` in 1, `m_bready_o` out 1: AXI write response channel

## Operation
- **States:**
  - IDLE
  - RD_ADDR
  - RD_DATA
  - WR_REQ
  - WR_RESP
  - RESP
- **IDLE:**
  - `req_ready_o` = 1.
  - When `req_valid_i` = 1, register the address as {addr[XLEN-1:2], 2'b00}, plus `we`, `wdata` and `wmask`.
  - Next state is RD_ADDR if `we` = 0, otherwise WR_REQ.
- **RD_ADDR:**
  - `m_arvalid_o` = 1 and `m_araddr_o` = registered address; both stay stable until `m_arready_i`.
  - On `m_arready_i`, go to RD_DATA.
- **RD_DATA:**
  - `m_rready_o` = 1.
  - On `m_rvalid_i`, capture `rdata` and set `err` = `m_rresp_i[1]`, then go to RESP.
- **WR_REQ:**
  - `m_awvalid_o` and `m_wvalid_o` both rise on entry.
  - Each valid drops independently after its own ready handshake; per-channel done flags track this.
  - When both channels are done (same cycle or different cycles), go to WR_RESP.
  - `m_wstrb_o` = registered mask. A mask of 4'b0000 is still issued.
- **WR_RESP:**
  - `m_bready_o` = 1.
  - On `m_bvalid_i`, set `err` = `m_bresp_i[1]` and `rdata` = 0, then go to RESP.
- **RESP:**
  - `resp_valid_o` = 1; `resp_rdata_o` and `resp_err_o` stay stable until `resp_ready_i`.
  - On `resp_ready_i`, return to IDLE.
  - `req_ready_o` = 0 here; no back-to-back accept in this cycle.
- All AXI valid/ready outputs are driven from registered state; there is no combinational path from `m_*_i` to `m_*_o`.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `req_ready_o` = 1, since it is decoded from IDLE.
  - All `m_*valid_o`, `m_rready_o`, `m_bready_o`, `resp_valid_o` and `resp_err_o` = 0.
  - `resp_rdata_o` and all `m_*addr_o`/`m_wdata_o`/`m_wstrb_o` = 0.
- **Reset mid-transaction:** outputs clear immediately and asynchronously; the transaction is abandoned with no response.
- **Minimum load latency:**
  - Request accepted at edge N.
  - ARVALID is high in cycle N+1; ARREADY is sampled then.
  - RREADY is high in N+2.
  - `resp_valid_o` is high in N+3.
- **Minimum store latency:** same three cycles (WR_REQ → WR_RESP → RESP).
- Slave-ready delays add cycle-for-cycle.
- Throughput: at most one transaction per 4 cycles.
- `req_*` inputs are sampled only on the accept edge; later changes are ignored.

## Configuration
- **`LSU_BRIDGE_TIMEOUT_EN` defined:**
  - A counter, `$clog2(TIMEOUT_CYCLES+1)` bits wide, clears on accept and increments every cycle in RD_ADDR, RD_DATA, WR_REQ and WR_RESP.
  - On reaching `TIMEOUT_CYCLES`, all `m_*valid_o`/`m_*ready_o` drop and the block goes to RESP with `err` = 1 and `rdata` = 0.
  - This is a simulation hang-detector only, and intentionally AXI non-compliant.
- **Undefined:** no counter is built and the bridge waits indefinitely.

## Test plan
- **Reset:** hold `rst_ni` = 0 → `req_ready_o` = 1, every other output 0. Assert reset while in RD_DATA → `m_rready_o` drops in the same cycle, no response.
- **Zero-wait load:**
  - Stimulus: `req_addr_i` = 0x8000_0006, slave always ready, `m_rdata_i` = 0xDEAD_BEEF, RRESP = 0.
  - Response: `m_araddr_o` = 0x8000_0004 in cycle N+1; `resp_rdata_o` = 0xDEAD_BEEF with `err` = 0 at N+3.
- **Split-handshake store:**
  - Stimulus: `wdata` = 0x0000_AB00, mask = 4'b0010. AWREADY arrives at cycle +1, WREADY at cycle +4, BVALID 2 cycles later with BRESP = 2'b10.
  - Response: AWVALID low after its handshake, WVALID held until +4; `resp_err_o` = 1, `rdata` = 0.
- **Backpressure:** hold `resp_ready_i` = 0 for 5 cycles → `resp_valid_o` and data stable; `req_ready_o` = 0; a new `req_valid_i` is not accepted until the cycle after the RESP handshake.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 8):** slave never asserts ARREADY → ARVALID drops after 8 cycles, then `resp_valid_o` = 1 with `resp_err_o` = 1.

Source files
------------

// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge: turns one word-aligned LSU load/store into an AXI4-Lite
// transaction. Only one transaction is in flight at a time, and the LSU is
// stalled through req_ready_o while it runs.
// Optional feature: define LSU_BRIDGE_TIMEOUT_EN to add a hang watchdog.
// The watchdog completes a stuck transaction with err=1 after TIMEOUT_CYCLES.
module lsu_axi_bridge #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  // LSU request
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [3:0]      req_wmask_i,
  // LSU response
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  // AXI read address
  output logic [XLEN-1:0] m_araddr_o,
  output logic            m_arvalid_o,
  input  logic            m_arready_i,
  // AXI read data
  input  logic [XLEN-1:0] m_rdata_i,
  input  logic [1:0]      m_rresp_i,
  input  logic            m_rvalid_i,
  output logic            m_rready_o,
  // AXI write address
  output logic [XLEN-1:0] m_awaddr_o,
  output logic            m_awvalid_o,
  input  logic            m_awready_i,
  // AXI write data
  output logic [XLEN-1:0] m_wdata_o,
  output logic [3:0]      m_wstrb_o,
  output logic            m_wvalid_o,
  input  logic            m_wready_i,
  // AXI write response
  input  logic [1:0]      m_bresp_i,
  input  logic            m_bvalid_i,
  output logic            m_bready_o
);

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wmask;
  } req_t;

  state_e          state_q, state_d;
  req_t            req_q;
  logic            aw_done_q, w_done_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;
  logic            accept;
  logic            timeout;

  // Byte-offset bits and RESP[0] (EXOKAY) carry no meaning on this port.
  logic unused_bits;
  assign unused_bits = ^{req_addr_i[1:0], m_rresp_i[0], m_bresp_i[0]};

  assign accept = (state_q == IDLE) && req_valid_i;

`ifdef LSU_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The last waiting cycle is the one where the count is TIMEOUT_CYCLES-1.
  // That keeps a stuck valid high for exactly TIMEOUT_CYCLES cycles.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt_q;
  logic          waiting;

  assign waiting = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                   (state_q == WR_REQ)  || (state_q == WR_RESP);

  // Watchdog: restarts on every accept and counts only while stuck on the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      to_cnt_q <= '0;
    else if (accept)  to_cnt_q <= '0;
    else if (waiting) to_cnt_q <= to_cnt_q + CW'(1);
  end

  assign timeout = waiting && (to_cnt_q == TO_LAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. Every output below is decoded from registered state
  // only, so no AXI input reaches an AXI output combinationally.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    m_arvalid_o  = 1'b0;
    m_rready_o   = 1'b0;
    m_awvalid_o  = 1'b0;
    m_wvalid_o   = 1'b0;
    m_bready_o   = 1'b0;
    resp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_we_i ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: begin
        m_arvalid_o = 1'b1;
        if (m_arready_i) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_rready_o = 1'b1;
        if (m_rvalid_i) state_d = RESP;
      end
      WR_REQ: begin
        m_awvalid_o = !aw_done_q;
        m_wvalid_o  = !w_done_q;
        if ((aw_done_q || m_awready_i) && (w_done_q || m_wready_i))
          state_d = WR_RESP;
      end
      WR_RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) state_d = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = RESP;
  end

  // Request capture, per-channel write handshake tracking, and response capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else if (accept) begin
      req_q.we    <= req_we_i;
      req_q.addr  <= {req_addr_i[XLEN-1:2], 2'b00};
      req_q.wdata <= req_wdata_i;
      req_q.wmask <= req_wmask_i;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else if (timeout) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else begin
      unique case (state_q)
        RD_DATA: if (m_rvalid_i) begin
          rdata_q <= m_rdata_i;
          err_q   <= m_rresp_i[1];
        end
        WR_REQ: begin
          if (m_awready_i) aw_done_q <= 1'b1;
          if (m_wready_i)  w_done_q  <= 1'b1;
        end
        WR_RESP: if (m_bvalid_i) begin
          rdata_q <= '0;
          err_q   <= m_bresp_i[1];
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign m_araddr_o   = req_q.addr;
  assign m_awaddr_o   = req_q.addr;
  assign m_wdata_o    = req_q.wdata;
  assign m_wstrb_o    = req_q.wmask;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed bench for lsu_axi_bridge. It covers reset, a zero-wait load, a
// split-handshake store, a zero-mask store, response backpressure, reset in
// mid-transaction, and, with LSU_BRIDGE_TIMEOUT_EN defined, the watchdog.
module tb_lsu_axi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_we_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wmask_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] m_araddr_o, m_rdata_i, m_awaddr_o, m_wdata_o;
  logic        m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
  logic [1:0]  m_rresp_i, m_bresp_i;
  logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
  logic [3:0]  m_wstrb_o;
  logic        m_bvalid_i, m_bready_o;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_axi_bridge #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i),
    .m_rready_o(m_rready_o),
    .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o),
    .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic slave_idle();
    m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = '0; m_rresp_i = 0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] msk);
    req_valid_i = 1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wd; req_wmask_i = msk;
    tick();
    req_valid_i = 0; req_we_i = ~we; req_addr_i = 32'hFFFF_FFFF;
    req_wdata_i = 32'h5555_5555; req_wmask_i = 4'hF;
  endtask

  initial begin
    rst_ni = 0; req_valid_i = 0; req_we_i = 0; req_addr_i = '0;
    req_wdata_i = '0; req_wmask_i = '0; resp_ready_i = 0;
    slave_idle();
    #12;
    // Reset state
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_valids", {m_arvalid_o, m_rready_o, m_awvalid_o, m_wvalid_o,
                       m_bready_o, resp_valid_o, resp_err_o}, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    chk("rst_araddr", m_araddr_o, 0);
    chk("rst_awaddr", m_awaddr_o, 0);
    chk("rst_wdata", m_wdata_o, 0);
    chk("rst_wstrb", m_wstrb_o, 0);
    rst_ni = 1;
    tick();

    // Zero-wait load: the address is word-aligned; the response arrives at N+3.
    m_arready_i = 1; m_rvalid_i = 1; m_rdata_i = 32'hDEAD_BEEF; m_rresp_i = 0;
    issue(0, 32'h8000_0006, 0, 0);
    chk("ld_arvalid_n1", m_arvalid_o, 1);
    chk("ld_araddr_n1", m_araddr_o, 32'h8000_0004);
    chk("ld_req_ready_n1", req_ready_o, 0);
    tick();
    chk("ld_rready_n2", m_rready_o, 1);
    chk("ld_arvalid_n2", m_arvalid_o, 0);
    tick();
    chk("ld_resp_valid_n3", resp_valid_o, 1);
    chk("ld_rdata_n3", resp_rdata_o, 32'hDEAD_BEEF);
    chk("ld_err_n3", resp_err_o, 0);
    chk("ld_rready_n3", m_rready_o, 0);
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;
    chk("ld_back_idle", {req_ready_o, resp_valid_o}, 2'b10);
    slave_idle();

    // Split-handshake store: AWREADY arrives at +1, WREADY at +4, and BVALID at +6 with SLVERR.
    issue(1, 32'h0000_1002, 32'h0000_AB00, 4'b0010);
    m_awready_i = 1;
    chk("st_c1_valids", {m_awvalid_o, m_wvalid_o}, 2'b11);
    chk("st_awaddr", m_awaddr_o, 32'h0000_1000);
    chk("st_wdata", m_wdata_o, 32'h0000_AB00);
    chk("st_wstrb", m_wstrb_o, 4'b0010);
    tick();
    m_awready_i = 0;
    chk("st_c2_valids", {m_awvalid_o, m_wvalid_o}, 2'b01);
    tick();
    chk("st_c3_valids", {m_awvalid_o, m_wvalid_o}, 2'b01);
    tick();
    m_wready_i = 1;
    chk("st_c4_valids", {m_awvalid_o, m_wvalid_o, m_bready_o}, 3'b010);
    tick();
    m_wready_i = 0;
    chk("st_c5_bready", {m_wvalid_o, m_bready_o}, 2'b01);
    tick();
    m_bvalid_i = 1; m_bresp_i = 2'b10;
    chk("st_c6_bready", m_bready_o, 1);
    tick();
    slave_idle();
    chk("st_resp_valid", resp_valid_o, 1);
    chk("st_resp_err", resp_err_o, 1);
    chk("st_resp_rdata", resp_rdata_o, 0);

    // Backpressure: hold off resp_ready for 5 cycles while a new request waits.
    req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h0000_0020;
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", resp_valid_o, 1);
      chk("bp_resp_err", resp_err_o, 1);
      chk("bp_rdata", resp_rdata_o, 0);
      chk("bp_req_ready", req_ready_o, 0);
      tick();
    end
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;
    chk("bp_idle_after_hs", {req_ready_o, m_arvalid_o, resp_valid_o}, 3'b100);
    tick();
    req_valid_i = 0; req_addr_i = 32'h0000_0FFC;
    chk("bp_new_ld_arvalid", m_arvalid_o, 1);
    chk("bp_new_ld_addr", m_araddr_o, 32'h0000_0020);
    m_arready_i = 1;
    tick();
    m_arready_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h1234_5678; m_rresp_i = 2'b11;
    tick();
    slave_idle();
    chk("rderr_rdata", resp_rdata_o, 32'h1234_5678);
    chk("rderr_err", resp_err_o, 1);
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;

    // A zero-mask store is still issued; both channels complete in the same cycle.
    // BRESP 01 has bit 1 clear, so no error is reported.
    issue(1, 32'h0000_0040, 32'hCAFE_F00D, 4'b0000);
    chk("st0_wvalid", {m_awvalid_o, m_wvalid_o}, 2'b11);
    chk("st0_wstrb", m_wstrb_o, 0);
    m_awready_i = 1; m_wready_i = 1;
    tick();
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 1; m_bresp_i = 2'b01;
    chk("st0_bready", {m_awvalid_o, m_wvalid_o, m_bready_o}, 3'b001);
    tick();
    slave_idle();
    chk("st0_resp", {resp_valid_o, resp_err_o}, 2'b10);
    chk("st0_rdata", resp_rdata_o, 0);
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;

    // Reset asserted during RD_DATA drops RREADY at once, and no response follows.
    issue(0, 32'h0000_0080, 0, 0);
    m_arready_i = 1;
    tick();
    m_arready_i = 0;
    chk("mr_rready_before", m_rready_o, 1);
    #2 rst_ni = 0;
    #1;
    chk("mr_rready_async", m_rready_o, 0);
    chk("mr_req_ready", req_ready_o, 1);
    tick();
    rst_ni = 1;
    m_rvalid_i = 1; m_rdata_i = 32'hBAD0_BAD0;
    tick();
    tick();
    slave_idle();
    chk("mr_no_resp", {resp_valid_o, m_rready_o}, 0);

`ifdef LSU_BRIDGE_TIMEOUT_EN
    // Watchdog: ARREADY never arrives, so ARVALID stays high for 8 cycles, then an error response follows.
    begin
      int hi_cycles;
      hi_cycles = 0;
      issue(0, 32'h0000_0100, 0, 0);
      for (int i = 0; i < 30 && m_arvalid_o; i++) begin
        hi_cycles++;
        tick();
      end
      chk("to_arvalid_cycles", hi_cycles, 8);
      chk("to_arvalid_low", m_arvalid_o, 0);
      chk("to_resp", {resp_valid_o, resp_err_o}, 2'b11);
      chk("to_rdata", resp_rdata_o, 0);
      resp_ready_i = 1;
      tick();
      resp_ready_i = 0;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
